// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline control unit: datapath widths,
// control-register addresses, STATUS bit positions, control-op and
// exception encodings, and the controller FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

   localparam int WORD_DATA = 32;
   localparam int WORD_ADDR = 30;
   localparam int ISA_EXP   = 3;
   localparam int CTRL_OP   = 2;
   localparam int REG_ADDR  = 5;

   // Control-register addresses
   localparam logic [REG_ADDR-1:0] CREG_STATUS     = 5'd0;
   localparam logic [REG_ADDR-1:0] CREG_PRE_STATUS = 5'd1;
   localparam logic [REG_ADDR-1:0] CREG_PC         = 5'd2;
   localparam logic [REG_ADDR-1:0] CREG_EPC        = 5'd3;
   localparam logic [REG_ADDR-1:0] CREG_EXP_VECTOR = 5'd4;
   localparam logic [REG_ADDR-1:0] CREG_CAUSE      = 5'd5;
   localparam logic [REG_ADDR-1:0] CREG_INT_MASK   = 5'd6;
   localparam logic [REG_ADDR-1:0] CREG_IRQ_PEND   = 5'd7;

   // STATUS = {30'b0, IE, EM}
   localparam int STATUS_EM = 0;
   localparam int STATUS_IE = 1;

   typedef enum logic [CTRL_OP-1:0] {
      CTRL_NOP  = 2'd0,
      CTRL_WRCR = 2'd1,
      CTRL_EXRT = 2'd2
   } ctrl_op_e;

   typedef enum logic [ISA_EXP-1:0] {
      EXP_NO_EXP     = 3'd0,
      EXP_EXT_INT    = 3'd1,
      EXP_UNDEF      = 3'd2,
      EXP_OVERFLOW   = 3'd3,
      EXP_MISS_ALIGN = 3'd4,
      EXP_TRAP       = 3'd5,
      EXP_PRV_VIO    = 3'd6
   } isa_exp_e;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_SETTLE = 1'b1
   } state_e;

endpackage

// File: rtl/pipe_ctrl_irq_sync.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_irq_sync
// 8-bit two-flop synchronizer for the asynchronous interrupt request lines.
// Only built when PIPE_CTRL_IRQ_EN is defined; otherwise this file is empty.
// Ports:
//   clk      in   core clock
//   reset_   in   synchronous active-high reset (clears both flop ranks)
//   IRQ      in   [7:0] asynchronous requests
//   IRQSync  out  [7:0] requests after two clk flops
// -----------------------------------------------------------------------------
`ifdef PIPE_CTRL_IRQ_EN
module pipe_ctrl_irq_sync (
   input  logic       clk,
   input  logic       reset_,
   input  logic [7:0] IRQ,
   output logic [7:0] IRQSync
);

   logic [7:0] meta_q;
   logic [7:0] sync_q;

   always_ff @(posedge clk) begin
      if (reset_) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= IRQ;
         sync_q <= meta_q;
      end
   end

   assign IRQSync = sync_q;

endmodule
`endif

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Pipeline control unit for the 5-stage core. Produces per-register
// Stall/Flush, the redirect target NewPC, and the IntDetect tag; commits
// exceptions, EXRT and control-register writes at the MEM/WB boundary and
// holds the control-register file.
// Build option: PIPE_CTRL_IRQ_EN enables the IRQ synchronizer, INT_MASK,
// IRQ_PEND and IntDetect; without it IntDetect is 0 and IRQ is ignored.
// Ports:
//   clk, reset_                  clock, synchronous active-high reset
//   IFBusy, MEMBusy, LoadHazard  stall sources
//   IRQ[7:0]                     asynchronous interrupt requests
//   MEMPC, MEMEn, MEMBrFlag,
//   MEMCtrlOp, MEMDstAddr,
//   MEMOut, MEMExpCode           MEM/WB slot being committed
//   CRegRdAddr / CRegRdData      control-register read port (combinational)
//   ExeMode                      0 = kernel, 1 = user (STATUS.EM)
//   IF/ID/EX/MEM Stall, Flush    per pipeline-register control
//   NewPC                        redirect target, valid while IFFlush=1
//   IntDetect                    tag next EX/MEM load as EXT_INT
// -----------------------------------------------------------------------------
module pipe_ctrl
   import pipe_ctrl_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset_,
   input  logic                 IFBusy,
   input  logic                 MEMBusy,
   input  logic                 LoadHazard,
   input  logic [7:0]           IRQ,
   input  logic [WORD_ADDR-1:0] MEMPC,
   input  logic                 MEMEn,
   input  logic                 MEMBrFlag,
   input  logic [CTRL_OP-1:0]   MEMCtrlOp,
   input  logic [REG_ADDR-1:0]  MEMDstAddr,
   input  logic [WORD_DATA-1:0] MEMOut,
   input  logic [ISA_EXP-1:0]   MEMExpCode,
   input  logic [REG_ADDR-1:0]  CRegRdAddr,
   output logic [WORD_DATA-1:0] CRegRdData,
   output logic                 ExeMode,
   output logic                 IFStall,
   output logic                 IDStall,
   output logic                 EXStall,
   output logic                 MEMStall,
   output logic                 IFFlush,
   output logic                 IDFlush,
   output logic                 EXFlush,
   output logic                 MEMFlush,
   output logic [WORD_ADDR-1:0] NewPC,
   output logic                 IntDetect
);

   function automatic logic creg_writable(input logic [REG_ADDR-1:0] a);
      logic w;
      case (a)
         CREG_STATUS, CREG_PRE_STATUS, CREG_EPC,
         CREG_EXP_VECTOR, CREG_CAUSE: w = 1'b1;
`ifdef PIPE_CTRL_IRQ_EN
         CREG_INT_MASK:               w = 1'b1;
`endif
         default:                     w = 1'b0;
      endcase
      return w;
   endfunction

   state_e               state_q;
   logic [1:0]           status_q,     status_d;
   logic [1:0]           pre_status_q, pre_status_d;
   logic [WORD_ADDR-1:0] epc_q,        epc_d;
   logic [WORD_ADDR-1:0] exp_vec_q,    exp_vec_d;
   logic [3:0]           cause_q,      cause_d;

   logic busy, commit_ok, exc_now, exrt_now, wrcr_now, flush_now;

   assign busy      = IFBusy | MEMBusy;
   // Gating with reset_ abandons any commit in a reset cycle.
   assign commit_ok = MEMEn & ~busy & ~reset_;
   assign exc_now   = commit_ok & (|MEMExpCode);
   assign exrt_now  = commit_ok & ~(|MEMExpCode) & (ctrl_op_e'(MEMCtrlOp) == CTRL_EXRT);
   assign wrcr_now  = commit_ok & ~(|MEMExpCode) & (ctrl_op_e'(MEMCtrlOp) == CTRL_WRCR);
   assign flush_now = exc_now | exrt_now;

   assign IFStall  = ~reset_ & (busy | LoadHazard);
   assign IDStall  = ~reset_ & (busy | LoadHazard);
   assign EXStall  = ~reset_ & busy;
   assign MEMStall = ~reset_ & busy;

   // A redirect flush also covers the load-use bubble into ID/EX.
   assign IFFlush  = flush_now;
   assign IDFlush  = flush_now | (~reset_ & LoadHazard & ~busy);
   assign EXFlush  = flush_now;
   assign MEMFlush = flush_now;

   assign NewPC    = exc_now ? exp_vec_q : (exrt_now ? epc_q : '0);
   assign ExeMode  = status_q[STATUS_EM];

`ifdef PIPE_CTRL_IRQ_EN
   logic [7:0] irq_synced;
   logic [7:0] int_mask_q, int_mask_d;

   pipe_ctrl_irq_sync u_irq_sync (
      .clk     (clk),
      .reset_  (reset_),
      .IRQ     (IRQ),
      .IRQSync (irq_synced)
   );

   // Suppressed in SETTLE so the first redirected fetch is never tagged.
   assign IntDetect = ~reset_ & status_q[STATUS_IE] & (|(irq_synced & ~int_mask_q))
                      & (state_q == ST_RUN) & ~flush_now;
`else
   logic unused_irq;
   assign unused_irq = ^IRQ;
   assign IntDetect  = 1'b0;
`endif

   // Next-state for the control-register file; exception > EXRT > WRCR.
   always_comb begin
      status_d     = status_q;
      pre_status_d = pre_status_q;
      epc_d        = epc_q;
      exp_vec_d    = exp_vec_q;
      cause_d      = cause_q;
`ifdef PIPE_CTRL_IRQ_EN
      int_mask_d   = int_mask_q;
`endif
      if (exc_now) begin
         // A delay-slot fault restarts at the branch one word earlier.
         epc_d        = MEMBrFlag ? (MEMPC - 30'd1) : MEMPC;
         cause_d      = {MEMBrFlag, MEMExpCode};
         pre_status_d = status_q;
         status_d     = '0;
      end else if (exrt_now) begin
         status_d     = pre_status_q;
      end else if (wrcr_now) begin
         case (MEMDstAddr)
            CREG_STATUS:     status_d     = MEMOut[1:0];
            CREG_PRE_STATUS: pre_status_d = MEMOut[1:0];
            CREG_EPC:        epc_d        = MEMOut[31:2];
            CREG_EXP_VECTOR: exp_vec_d    = MEMOut[31:2];
            CREG_CAUSE:      cause_d      = MEMOut[3:0];
`ifdef PIPE_CTRL_IRQ_EN
            CREG_INT_MASK:   int_mask_d   = MEMOut[7:0];
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset_) begin
         state_q      <= ST_RUN;
         status_q     <= '0;
         pre_status_q <= '0;
         exp_vec_q    <= '0;
`ifdef PIPE_CTRL_IRQ_EN
         int_mask_q   <= 8'hFF;
`endif
      end else begin
         status_q     <= status_d;
         pre_status_q <= pre_status_d;
         exp_vec_q    <= exp_vec_d;
`ifdef PIPE_CTRL_IRQ_EN
         int_mask_q   <= int_mask_d;
`endif
         case (state_q)
            ST_RUN:    if (flush_now) state_q <= ST_SETTLE;
            ST_SETTLE: state_q <= ST_RUN;
            default:   state_q <= ST_RUN;
         endcase
      end
   end

   // EPC and CAUSE carry no reset value; they are always written before use.
   always_ff @(posedge clk) begin
      epc_q   <= epc_d;
      cause_q <= cause_d;
   end

   // Read port with same-cycle WRCR bypass.
   always_comb begin
      case (CRegRdAddr)
         CREG_STATUS:     CRegRdData = {30'b0, status_q};
         CREG_PRE_STATUS: CRegRdData = {30'b0, pre_status_q};
         CREG_PC:         CRegRdData = {MEMPC, 2'b00};
         CREG_EPC:        CRegRdData = {epc_q, 2'b00};
         CREG_EXP_VECTOR: CRegRdData = {exp_vec_q, 2'b00};
         CREG_CAUSE:      CRegRdData = {28'b0, cause_q};
`ifdef PIPE_CTRL_IRQ_EN
         CREG_INT_MASK:   CRegRdData = {24'b0, int_mask_q};
         CREG_IRQ_PEND:   CRegRdData = {24'b0, irq_synced};
`endif
         default:         CRegRdData = '0;
      endcase
      if (wrcr_now && (MEMDstAddr == CRegRdAddr) && creg_writable(MEMDstAddr))
         CRegRdData = MEMOut;
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        reset_;
   logic        IFBusy, MEMBusy, LoadHazard;
   logic [7:0]  IRQ;
   logic [29:0] MEMPC;
   logic        MEMEn, MEMBrFlag;
   logic [1:0]  MEMCtrlOp;
   logic [4:0]  MEMDstAddr;
   logic [31:0] MEMOut;
   logic [2:0]  MEMExpCode;
   logic [4:0]  CRegRdAddr;
   logic [31:0] CRegRdData;
   logic        ExeMode;
   logic        IFStall, IDStall, EXStall, MEMStall;
   logic        IFFlush, IDFlush, EXFlush, MEMFlush;
   logic [29:0] NewPC;
   logic        IntDetect;

   int ntests = 0;
   int nfail  = 0;

   pipe_ctrl dut (
      .clk(clk), .reset_(reset_), .IFBusy(IFBusy), .MEMBusy(MEMBusy),
      .LoadHazard(LoadHazard), .IRQ(IRQ), .MEMPC(MEMPC), .MEMEn(MEMEn),
      .MEMBrFlag(MEMBrFlag), .MEMCtrlOp(MEMCtrlOp), .MEMDstAddr(MEMDstAddr),
      .MEMOut(MEMOut), .MEMExpCode(MEMExpCode), .CRegRdAddr(CRegRdAddr),
      .CRegRdData(CRegRdData), .ExeMode(ExeMode),
      .IFStall(IFStall), .IDStall(IDStall), .EXStall(EXStall), .MEMStall(MEMStall),
      .IFFlush(IFFlush), .IDFlush(IDFlush), .EXFlush(EXFlush), .MEMFlush(MEMFlush),
      .NewPC(NewPC), .IntDetect(IntDetect)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       ifb, memb, lh, en;
      logic [1:0] op;
      logic [2:0] code;
      logic [3:0] stall;   // {IF,ID,EX,MEM}
      logic [3:0] flush;   // {IF,ID,EX,MEM}
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] stalls();
      return {28'b0, IFStall, IDStall, EXStall, MEMStall};
   endfunction

   function automatic logic [31:0] flushes();
      return {28'b0, IFFlush, IDFlush, EXFlush, MEMFlush};
   endfunction

   task automatic idle();
      IFBusy = 0; MEMBusy = 0; LoadHazard = 0; MEMEn = 0; MEMBrFlag = 0;
      MEMCtrlOp = 2'd0; MEMExpCode = 3'd0;
   endtask

   task automatic rd(input string nm, input logic [4:0] a, input logic [31:0] exp);
      CRegRdAddr = a;
      #1;
      chk(nm, CRegRdData, exp);
   endtask

   // Commit one WRCR at the next posedge.
   task automatic wrcr(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      idle();
      MEMEn = 1; MEMCtrlOp = 2'd1; MEMDstAddr = a; MEMOut = d;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 4'b0000, 4'b0000};
      tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 4'b1100, 4'b0100};
      tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 4'b1111, 4'b0000};
      tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 3'd0, 4'b1111, 4'b0000};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 3'd3, 4'b0000, 4'b1111};
      tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 3'd3, 4'b1111, 4'b0000};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 3'd0, 4'b0000, 4'b1111};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 3'd0, 4'b0000, 4'b0000};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd5, 4'b0000, 4'b0000};
      tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 3'd2, 4'b1100, 4'b1111};
      tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 3'd0, 4'b1111, 4'b0000};
      tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 3'd0, 4'b1100, 4'b1111};

      // Reset, with hazard and a pending exception present: outputs quiet
      reset_ = 1; idle(); IRQ = 8'h00; MEMPC = 30'h0; MEMDstAddr = 5'd31;
      MEMOut = 32'h0; CRegRdAddr = 5'd0;
      @(negedge clk);
      LoadHazard = 1; MEMEn = 1; MEMExpCode = 3'd3;
      #1;
      chk("rst_stall", stalls(), 32'h0);
      chk("rst_flush", flushes(), 32'h0);
      chk("rst_newpc", {2'b0, NewPC}, 32'h0);
      chk("rst_intdet", {31'b0, IntDetect}, 32'h0);
      @(negedge clk);
      reset_ = 0; idle();
      #1;
      chk("rst_exemode", {31'b0, ExeMode}, 32'h0);
      rd("rst_status", 5'd0, 32'h0);
      rd("rst_prestatus", 5'd1, 32'h0);
      rd("rst_expvec", 5'd4, 32'h0);

      // Table of combinational Stall/Flush vectors (no commit reaches an edge)
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         IFBusy = tbl[i].ifb; MEMBusy = tbl[i].memb; LoadHazard = tbl[i].lh;
         MEMEn = tbl[i].en; MEMCtrlOp = tbl[i].op; MEMExpCode = tbl[i].code;
         #1;
         chk($sformatf("vec%0d_stall", i), stalls(), {28'b0, tbl[i].stall});
         chk($sformatf("vec%0d_flush", i), flushes(), {28'b0, tbl[i].flush});
         idle();
      end

      // WRCR EXP_VECTOR with same-cycle bypass read
      wrcr(5'd4, 32'h0000_1000);
      CRegRdAddr = 5'd4; #1;
      chk("wrcr_bypass", CRegRdData, 32'h0000_1000);
      chk("wrcr_noflush", flushes(), 32'h0);
      @(negedge clk); idle();
      rd("expvec_rd", 5'd4, 32'h0000_1000);

      wrcr(5'd0, 32'h3);
      @(negedge clk); idle();
      rd("status_wr", 5'd0, 32'h3);
      chk("exemode_user", {31'b0, ExeMode}, 32'h1);

      // TRAP commit at MEMPC=0x40
      @(negedge clk); idle();
      MEMEn = 1; MEMExpCode = 3'd5; MEMPC = 30'h40; #1;
      chk("trap_flush", flushes(), 32'hF);
      chk("trap_newpc", {2'b0, NewPC}, 32'h400);
      @(negedge clk); idle();
      rd("trap_epc", 5'd3, 32'h100);
      rd("trap_cause", 5'd5, 32'h5);
      rd("trap_status", 5'd0, 32'h0);
      @(negedge clk);
      rd("trap_prestatus", 5'd1, 32'h3);
      chk("trap_exemode", {31'b0, ExeMode}, 32'h0);

      // Delay-slot exception
      @(negedge clk); idle();
      MEMEn = 1; MEMExpCode = 3'd2; MEMBrFlag = 1; MEMPC = 30'h41; #1;
      chk("dly_flush", flushes(), 32'hF);
      @(negedge clk); idle();
      rd("dly_epc", 5'd3, 32'h100);
      rd("dly_cause", 5'd5, 32'hA);

      // EXRT back to PRE_STATUS=3
      wrcr(5'd1, 32'h3);
      @(negedge clk); idle();
      MEMEn = 1; MEMCtrlOp = 2'd2; #1;
      chk("exrt_newpc", {2'b0, NewPC}, 32'h40);
      chk("exrt_flush", flushes(), 32'hF);
      @(negedge clk); idle();
      rd("exrt_status", 5'd0, 32'h3);
      chk("exrt_exemode", {31'b0, ExeMode}, 32'h1);
      chk("exrt_settle_int", {31'b0, IntDetect}, 32'h0);

      // Pending OVERFLOW held while MEMBusy
      @(negedge clk); idle();
      MEMBusy = 1; LoadHazard = 1; MEMEn = 1; MEMExpCode = 3'd3; MEMPC = 30'h55; #1;
      chk("busy_stall", stalls(), 32'hF);
      chk("busy_flush", flushes(), 32'h0);
      @(negedge clk);
      rd("busy_cause_held", 5'd5, 32'hA);
      chk("busy_flush2", flushes(), 32'h0);
      @(negedge clk);
      MEMBusy = 0; #1;
      chk("unbusy_flush", flushes(), 32'hF);
      chk("unbusy_stall", stalls(), 32'hC);
      chk("unbusy_newpc", {2'b0, NewPC}, 32'h400);
      @(negedge clk); idle();
      rd("ovf_cause", 5'd5, 32'h3);
      rd("ovf_epc", 5'd3, 32'h154);

      // Reset in the middle of a redirect: commit abandoned
      @(negedge clk); idle();
      reset_ = 1; MEMEn = 1; MEMExpCode = 3'd6; MEMPC = 30'h77; #1;
      chk("rstmid_flush", flushes(), 32'h0);
      @(negedge clk); idle(); reset_ = 0;
      rd("rstmid_cause", 5'd5, 32'h3);
      rd("rstmid_epc", 5'd3, 32'h154);
      rd("rstmid_expvec", 5'd4, 32'h0);

`ifdef PIPE_CTRL_IRQ_EN
      rd("irq_mask_rst", 5'd6, 32'hFF);
      wrcr(5'd0, 32'h2);
      wrcr(5'd6, 32'hFE);
      @(negedge clk); idle();
      IRQ = 8'h01; #1;
      chk("irq_t0", {31'b0, IntDetect}, 32'h0);
      @(negedge clk); #1;
      chk("irq_t1", {31'b0, IntDetect}, 32'h0);
      @(negedge clk);
      rd("irq_pend", 5'd7, 32'h1);
      chk("irq_t2", {31'b0, IntDetect}, 32'h1);
      wrcr(5'd1, 32'h2);
      #1;
      chk("irq_during_wrcr", {31'b0, IntDetect}, 32'h1);
      @(negedge clk); idle();
      MEMEn = 1; MEMCtrlOp = 2'd2; #1;
      chk("irq_exrt_cycle", {31'b0, IntDetect}, 32'h0);
      chk("irq_exrt_newpc", {2'b0, NewPC}, 32'h55);
      @(negedge clk); idle(); #1;
      chk("irq_settle", {31'b0, IntDetect}, 32'h0);
      @(negedge clk); #1;
      chk("irq_after_settle", {31'b0, IntDetect}, 32'h1);
      wrcr(5'd6, 32'hFF);
      @(negedge clk); idle(); #1;
      chk("irq_masked", {31'b0, IntDetect}, 32'h0);
`else
      IRQ = 8'hFF;
      wrcr(5'd0, 32'h2);
      @(negedge clk); idle();
      @(negedge clk);
      @(negedge clk); #1;
      chk("noirq_intdet", {31'b0, IntDetect}, 32'h0);
      rd("noirq_mask", 5'd6, 32'h0);
      rd("noirq_pend", 5'd7, 32'h0);
      wrcr(5'd6, 32'h0000_00AB);
      CRegRdAddr = 5'd6; #1;
      chk("noirq_nobypass", CRegRdData, 32'h0);
      @(negedge clk); idle();
      rd("noirq_mask_after", 5'd6, 32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
